// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with a 2-bit saturating BHT plus lookup/mispredict counters.
// Optional gshare BHT indexing is enabled with `define BRANCH_PREDICTOR_GSHARE_EN.
module branch_predictor #(
    parameter int IDX_BITS = 6,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [31:0]      if_pc,
    input  logic             if_stall,
    output logic             pred_taken,
    output logic [31:0]      pred_target,
    output logic             pred_hit,
    input  logic             ex_update,
    input  logic [31:0]      ex_pc,
    input  logic             ex_is_branch,
    input  logic [1:0]       ex_jump,
    input  logic             ex_taken,
    input  logic [31:0]      ex_real_target,
    input  logic             ex_mispredict,
    output logic [CNT_W-1:0] lookup_cnt,
    output logic [CNT_W-1:0] mispredict_cnt
);
    localparam int TAG_BITS = 30 - IDX_BITS;
    localparam int ENTRIES  = 1 << IDX_BITS;

    logic                valid_r  [ENTRIES];
    logic [TAG_BITS-1:0] tag_r    [ENTRIES];
    logic [31:0]         target_r [ENTRIES];
    logic [1:0]          ctr_r    [ENTRIES];
    logic [CNT_W-1:0]    lookup_cnt_r;
    logic [CNT_W-1:0]    mispredict_cnt_r;

    logic [IDX_BITS-1:0] ridx_s;
    logic [IDX_BITS-1:0] widx_s;
    logic [IDX_BITS-1:0] bht_ridx_s;
    logic [IDX_BITS-1:0] bht_widx_s;
    logic [TAG_BITS-1:0] rtag_s;
    logic [TAG_BITS-1:0] wtag_s;
    logic                is_jump_s;
    logic                btb_wr_s;
    logic                bht_wr_s;
    logic [1:0]          ctr_wdata_s;
    logic                hit_s;
    logic                taken_s;
    logic [31:0]         target_s;
    logic                pc_lsb_unused_s;

    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        if (taken) begin
            res = (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
        end else begin
            res = (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
        end
        return res;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
        logic [CNT_W-1:0] res;
        if (val == {CNT_W{1'b1}}) begin
            res = val;
        end else begin
            res = val + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return res;
    endfunction

    assign ridx_s          = if_pc[IDX_BITS+1:2];
    assign rtag_s          = if_pc[31:IDX_BITS+2];
    assign widx_s          = ex_pc[IDX_BITS+1:2];
    assign wtag_s          = ex_pc[31:IDX_BITS+2];
    assign pc_lsb_unused_s = ^ex_pc[1:0];

`ifdef BRANCH_PREDICTOR_GSHARE_EN
    logic [IDX_BITS-1:0] ghr_r;
    logic                br_upd_s;

    assign br_upd_s   = ex_update && ex_is_branch && !is_jump_s;
    assign bht_ridx_s = ridx_s ^ ghr_r;
    assign bht_widx_s = widx_s ^ ghr_r;

    // Non-speculative global history, shifted only by resolved conditional branches
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ghr_r <= {IDX_BITS{1'b0}};
        end else if (br_upd_s) begin
            ghr_r <= {ghr_r[IDX_BITS-2:0], ex_taken};
        end
    end
`else
    assign bht_ridx_s = ridx_s;
    assign bht_widx_s = widx_s;
`endif

    // Decode the EX resolution into BTB/BHT write enables; jumps override the branch flag
    always_comb begin
        is_jump_s = (ex_jump != 2'b00);
        btb_wr_s  = ex_update && (is_jump_s || (ex_is_branch && ex_taken));
        bht_wr_s  = ex_update && (is_jump_s || ex_is_branch);
        if (is_jump_s) begin
            ctr_wdata_s = 2'b11;
        end else begin
            ctr_wdata_s = ctr_next(ctr_r[bht_widx_s], ex_taken);
        end
    end

    // Fetch-side lookup; reads pre-update table contents so same-cycle writes are not bypassed
    always_comb begin
        hit_s   = valid_r[ridx_s] && (tag_r[ridx_s] == rtag_s);
        taken_s = hit_s && ctr_r[bht_ridx_s][1];
        if (taken_s) begin
            target_s = target_r[ridx_s];
        end else begin
            target_s = if_pc + 32'd4;
        end
    end

    assign pred_hit       = hit_s;
    assign pred_taken     = taken_s;
    assign pred_target    = target_s;
    assign lookup_cnt     = lookup_cnt_r;
    assign mispredict_cnt = mispredict_cnt_r;

    // BTB entries: written only by taken branches and jumps, overwriting any alias
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_r[i]  <= 1'b0;
                tag_r[i]    <= {TAG_BITS{1'b0}};
                target_r[i] <= 32'd0;
            end
        end else if (btb_wr_s) begin
            valid_r[widx_s]  <= 1'b1;
            tag_r[widx_s]    <= wtag_s;
            target_r[widx_s] <= ex_real_target;
        end
    end

    // BHT counters start weakly not-taken and train on every resolved branch or jump
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_r[i] <= 2'b01;
            end
        end else if (bht_wr_s) begin
            ctr_r[bht_widx_s] <= ctr_wdata_s;
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lookup_cnt_r     <= {CNT_W{1'b0}};
            mispredict_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (!if_stall) begin
                lookup_cnt_r <= sat_inc(lookup_cnt_r);
            end
            if (ex_update && ex_mispredict) begin
                mispredict_cnt_r <= sat_inc(mispredict_cnt_r);
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (default and CNT_W=4 instances).
module tb_branch_predictor;
    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] if_pc;
    logic        if_stall;
    logic        ex_update;
    logic [31:0] ex_pc;
    logic        ex_is_branch;
    logic [1:0]  ex_jump;
    logic        ex_taken;
    logic [31:0] ex_real_target;
    logic        ex_mispredict;

    logic        pred_taken, pred_hit;
    logic [31:0] pred_target;
    logic [31:0] lookup_cnt, mispredict_cnt;
    logic        s_taken, s_hit;
    logic [31:0] s_target;
    logic [3:0]  s_lookup_cnt, s_mispredict_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    branch_predictor dut (
        .clk(clk), .rstn(rstn), .if_pc(if_pc), .if_stall(if_stall),
        .pred_taken(pred_taken), .pred_target(pred_target), .pred_hit(pred_hit),
        .ex_update(ex_update), .ex_pc(ex_pc), .ex_is_branch(ex_is_branch),
        .ex_jump(ex_jump), .ex_taken(ex_taken), .ex_real_target(ex_real_target),
        .ex_mispredict(ex_mispredict), .lookup_cnt(lookup_cnt), .mispredict_cnt(mispredict_cnt)
    );

    branch_predictor #(.IDX_BITS(6), .CNT_W(4)) dut_small (
        .clk(clk), .rstn(rstn), .if_pc(if_pc), .if_stall(if_stall),
        .pred_taken(s_taken), .pred_target(s_target), .pred_hit(s_hit),
        .ex_update(ex_update), .ex_pc(ex_pc), .ex_is_branch(ex_is_branch),
        .ex_jump(ex_jump), .ex_taken(ex_taken), .ex_real_target(ex_real_target),
        .ex_mispredict(ex_mispredict), .lookup_cnt(s_lookup_cnt), .mispredict_cnt(s_mispredict_cnt)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_upd(input logic [31:0] pc, input logic br, input logic [1:0] jmp,
                           input logic tk, input logic [31:0] tgt, input logic mp);
        ex_update      = 1'b1;
        ex_pc          = pc;
        ex_is_branch   = br;
        ex_jump        = jmp;
        ex_taken       = tk;
        ex_real_target = tgt;
        ex_mispredict  = mp;
    endtask

    task automatic clr_upd();
        ex_update     = 1'b0;
        ex_is_branch  = 1'b0;
        ex_jump       = 2'b00;
        ex_taken      = 1'b0;
        ex_mispredict = 1'b0;
    endtask

    task automatic check_pred(input string tag, input logic hit, input logic tk, input logic [31:0] tgt);
        check_val({tag, "_hit"}, {31'd0, pred_hit}, {31'd0, hit});
        check_val({tag, "_taken"}, {31'd0, pred_taken}, {31'd0, tk});
        check_val({tag, "_target"}, pred_target, tgt);
    endtask

    initial begin
        rstn = 1'b0; if_pc = 32'h100; if_stall = 1'b1;
        ex_pc = 32'd0; ex_real_target = 32'd0;
        clr_upd();
        #3;
        check_pred("por", 1'b0, 1'b0, 32'h104);
        step(); step();
        rstn = 1'b1;
        if_stall = 1'b0;

        // Training at 0x200 (index 0): ctr 01 -> 10 -> 11, then down to 00
        if_pc = 32'h200;
        set_upd(32'h200, 1'b1, 2'b00, 1'b1, 32'h180, 1'b0);
        #1 check_val("train_cold_hit", {31'd0, pred_hit}, 32'd0);
        step(); clr_upd();
        check_pred("train1", 1'b1, 1'b1, 32'h180);
        set_upd(32'h200, 1'b1, 2'b00, 1'b1, 32'h180, 1'b0); step();
        set_upd(32'h200, 1'b1, 2'b00, 1'b0, 32'h0, 1'b0); step(); clr_upd();
        check_pred("nt1", 1'b1, 1'b1, 32'h180);
        set_upd(32'h200, 1'b1, 2'b00, 1'b0, 32'h0, 1'b0); step(); clr_upd();
        check_pred("nt2", 1'b1, 1'b0, 32'h204);
        set_upd(32'h200, 1'b1, 2'b00, 1'b0, 32'h0, 1'b0); step();
        set_upd(32'h200, 1'b1, 2'b00, 1'b0, 32'h0, 1'b0); step(); clr_upd();
        check_pred("nt4", 1'b1, 1'b0, 32'h204);

        // Jump on an entry driven to ctr=0 by a not-taken branch
        set_upd(32'h40, 1'b1, 2'b00, 1'b0, 32'h0, 1'b0); step();
        set_upd(32'h40, 1'b0, 2'b01, 1'b0, 32'h1000, 1'b0); step(); clr_upd();
        if_pc = 32'h40;
        #1 check_pred("jump", 1'b1, 1'b1, 32'h1000);

        // Jump wins over branch flag with ex_taken low
        set_upd(32'hC0, 1'b1, 2'b10, 1'b0, 32'h500, 1'b0); step(); clr_upd();
        if_pc = 32'hC0;
        #1 check_pred("jump_prio", 1'b1, 1'b1, 32'h500);

        // Alias: 0x300 shares index 0 with 0x200 (ctr 00 -> 11 after three takens)
        repeat (3) begin
            set_upd(32'h200, 1'b1, 2'b00, 1'b1, 32'h180, 1'b0); step();
        end
        clr_upd();
        if_pc = 32'h300;
        #1 check_pred("alias_lookup", 1'b0, 1'b0, 32'h304);
        set_upd(32'h300, 1'b1, 2'b00, 1'b0, 32'h0, 1'b0); step(); clr_upd();
        if_pc = 32'h200;
        #1 check_pred("alias_keep", 1'b1, 1'b1, 32'h180);

        // Same-cycle update and lookup on a cold entry
        if_pc = 32'h80;
        set_upd(32'h80, 1'b1, 2'b00, 1'b1, 32'h20, 1'b0);
        #1 check_val("samecyc_hit", {31'd0, pred_hit}, 32'd0);
        step(); clr_upd();
        check_pred("samecyc_next", 1'b1, 1'b1, 32'h20);

        // Asynchronous reset mid-run
        if_pc = 32'h100;
        #2 rstn = 1'b0;
        #1;
        check_pred("rst", 1'b0, 1'b0, 32'h104);
        check_val("rst_lookup_cnt", lookup_cnt, 32'd0);
        check_val("rst_mispredict_cnt", mispredict_cnt, 32'd0);
        if_stall = 1'b1;
        step(); step();
        rstn = 1'b1;
        if_pc = 32'h200;
        #1 check_val("rst_forget_hit", {31'd0, pred_hit}, 32'd0);

        // Lookup counter: 10 edges, first 3 stalled
        for (int i = 0; i < 10; i++) begin
            if_stall = (i < 3);
            step();
        end
        if_stall = 1'b1;
        check_val("lookup_cnt", lookup_cnt, 32'd7);
        check_val("lookup_cnt_small", {28'd0, s_lookup_cnt}, 32'd7);

        // Mispredict counter and saturation at CNT_W=4
        repeat (3) begin
            set_upd(32'h400, 1'b1, 2'b00, 1'b0, 32'h0, 1'b1); step();
        end
        clr_upd();
        check_val("mispredict_cnt3", mispredict_cnt, 32'd3);
        check_val("mispredict_cnt3_small", {28'd0, s_mispredict_cnt}, 32'd3);
        repeat (17) begin
            set_upd(32'h400, 1'b1, 2'b00, 1'b0, 32'h0, 1'b1); step();
        end
        clr_upd();
        check_val("mispredict_cnt20", mispredict_cnt, 32'd20);
        check_val("mispredict_sat_small", {28'd0, s_mispredict_cnt}, 32'd15);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-side producer of the predicted next PC that the hazard unit later compares against the resolved target.
- Direct-mapped BTB with a 2-bit saturating-counter BHT.
- Looked up combinationally in IF; trained from EX on resolved branches and jumps.
- Also holds lookup and mispredict performance counters.

Parameters:
IDX_BITS, 6, log2 of table entries (BTB and BHT both have 2^IDX_BITS entries)
CNT_W, 32, width of each performance counter
(derived, not overridable) TAG_BITS = 30 - IDX_BITS; tag = pc[31:IDX_BITS+2]

Ports:
clk  in  1  clock, all state updates on posedge
rstn  in  1  asynchronous active-low reset
if_pc  in  32  PC of the instruction being fetched
if_stall  in  1  IF stage held this cycle
pred_taken  out  1  prediction: redirect fetch
pred_target  out  32  predicted next PC
pred_hit  out  1  BTB valid and tag match for if_pc
ex_update  in  1  resolved control instruction in EX this cycle (branch, or jump != 0)
ex_pc  in  32  PC of the resolved instruction
ex_is_branch  in  1  conditional branch
ex_jump  in  2  nonzero means JAL/JALR
ex_taken  in  1  branch outcome (ignored for jumps, which are always taken)
ex_real_target  in  32  resolved target
ex_mispredict  in  1  flush raised for this resolved instruction
lookup_cnt  out  CNT_W  number of non-stalled fetch cycles
mispredict_cnt  out  CNT_W  number of mispredicted resolutions

Behaviour:
- Storage per entry: valid (1), tag (TAG_BITS), target (32), ctr (2).
- rstn low, asynchronous: all valid = 0; all ctr = 2'b01 (weakly not-taken); both perf counters = 0.
- Reset output values: pred_hit = 0, pred_taken = 0, pred_target = if_pc + 4, counters = 0.
- Reset mid-training discards all learned state.
- Lookup (combinational, 0 cycles):
  - ridx = if_pc[IDX_BITS+1:2]
  - pred_hit = valid[ridx] && tag[ridx] == if_pc[31:IDX_BITS+2]
  - pred_taken = pred_hit && ctr[ridx][1]
  - pred_target = pred_taken ? target[ridx] : if_pc + 4 (32-bit wrap, no overflow flag)
  - Prediction ignores if_stall.
- Update (posedge, when ex_update = 1), widx = ex_pc[IDX_BITS+1:2]:
  - Branch: ctr increments when ex_taken (saturates at 3), else decrements (saturates at 0).
  - Jump (ex_jump != 0): ctr forced to 3. Jumps take priority over ex_is_branch if both are set.
  - Taken branch or jump: valid = 1, tag = ex_pc tag, target = ex_real_target, overwriting any aliased entry.
  - Not-taken branch: valid, tag and target unchanged, including when the tag mismatches.
  - ex_update = 0: no state change.
- Simultaneous update and lookup on the same index in one cycle: lookup returns the pre-update value (no bypass). The new value is visible the next cycle.
- Performance counters:
  - lookup_cnt += 1 on each posedge with !if_stall.
  - mispredict_cnt += 1 on each posedge with ex_update && ex_mispredict.
  - Both saturate at all-ones and never wrap.
- if_stall does not block updates.

Optional Feature:
- Macro: BRANCH_PREDICTOR_GSHARE_EN.
- Defined:
  - Adds an IDX_BITS-wide global history register ghr, reset to 0.
  - On posedge with ex_update && ex_is_branch && ex_jump == 0: ghr = {ghr[IDX_BITS-2:0], ex_taken}.
  - BHT read index = ridx ^ ghr. BHT write index = widx ^ ghr, using ghr before this cycle's shift.
  - BTB indexing stays PC-only.
  - History is non-speculative: updated from EX only.
- Undefined: no ghr; BHT indexed by PC only, exactly as above.

Test Plan:
- Reset: rstn low mid-run, if_pc=0x100 -> pred_hit=0, pred_taken=0, pred_target=0x104, lookup_cnt=0, mispredict_cnt=0, all without waiting for a clock edge.
- Training: two updates of branch ex_pc=0x200, taken, target 0x180 -> after the first, lookup of 0x200 gives pred_hit=1, pred_taken=1 (ctr 01->10), pred_target=0x180; four not-taken updates -> ctr saturates at 0, pred_taken=0, pred_target=0x204, pred_hit stays 1.
- Jump: ex_jump=2'b01, ex_pc=0x40, target 0x1000 on an entry with ctr=0 -> next-cycle lookup of 0x40 gives pred_taken=1, pred_target=0x1000.
- Alias (IDX_BITS=6): train 0x200 taken, then look up 0x300 (same index, different tag) -> pred_hit=0, pred_target=0x304; a not-taken branch update at 0x300 leaves the 0x200 entry intact.
- Same-cycle read/write: update 0x80 taken with target 0x20 while if_pc=0x80 on a cold entry -> that cycle pred_hit=0; next cycle pred_hit=1, pred_taken=1.
- Counters: 10 cycles with if_stall high for 3 -> lookup_cnt=7; 3 updates with ex_mispredict=1 -> mispredict_cnt=3; with CNT_W=4, 20 mispredicts -> mispredict_cnt holds at 15.
